stopwatch_bcd: RTL and testbench

- Timekeeping stage directly downstream of the frequency divider.
- Consumes the divider's slow square wave, sampled in the system clock domain, as a tick source.
- Prescales ticks to 1 s, runs a BCD MM:SS stopwatch (00:00-59:59) under start/stop and clear buttons.
- Drives four BCD digits for the 7-segment display stage.

---
 rtl/stopwatch_bcd_if.sv | 29 ++
 rtl/stopwatch_bcd.sv | 122 ++++++++++++
 tb/tb_stopwatch_bcd.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_bcd_if.sv
// rtl/stopwatch_bcd_if.sv - button/tick inputs and BCD display outputs of the stopwatch
// Signals:
//   iDivClk, iStartStop, iClear : level inputs; the stopwatch acts on their rising edges
//   oSec_ones, oSec_tens         : BCD seconds digits
//   oMin_ones, oMin_tens         : BCD minutes digits
//   oRun                         : high while counting
//   oWrap                        : one-cycle pulse on 59:59 -> 00:00
// Modports: slave = stopwatch side, master = driver/display side.
interface stopwatch_bcd_if;
  logic       iDivClk;
  logic       iStartStop;
  logic       iClear;
  logic [3:0] oSec_ones;
  logic [3:0] oSec_tens;
  logic [3:0] oMin_ones;
  logic [3:0] oMin_tens;
  logic       oRun;
  logic       oWrap;

  modport slave (
    input  iDivClk, iStartStop, iClear,
    output oSec_ones, oSec_tens, oMin_ones, oMin_tens, oRun, oWrap
  );

  modport master (
    output iDivClk, iStartStop, iClear,
    input  oSec_ones, oSec_tens, oMin_ones, oMin_tens, oRun, oWrap
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - BCD MM:SS stopwatch driven by the divider's slow square wave
// Ports:
//   iClk_in : system clock
//   iRst    : synchronous active-high reset
//   bus     : stopwatch_bcd_if.slave (tick/button inputs, BCD digits, oRun, oWrap)
// Parameter TICKS_PER_SEC (1..255): iDivClk rising edges per one-second step.
module stopwatch_bcd #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic           iClk_in,
  input  logic           iRst,
  stopwatch_bcd_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  localparam logic [7:0] LP_PRESC_LAST = 8'(TICKS_PER_SEC - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_div_prev, r_ss_prev, r_clr_prev;
  logic       w_div_edge, w_ss_edge, w_clr_edge;
  logic [7:0] r_presc;
  logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
  logic       r_run, r_wrap;
  logic       w_count, w_sec_tick;
  logic       w_c0, w_c1, w_c2, w_wrap;
  logic [3:0] w_sec_ones_n, w_sec_tens_n, w_min_ones_n, w_min_tens_n;

  // Prev registers double as the iClk_in-domain sample of each input.
  always_comb begin
    w_div_edge = bus.iDivClk    & ~r_div_prev;
    w_ss_edge  = bus.iStartStop & ~r_ss_prev;
    w_clr_edge = bus.iClear     & ~r_clr_prev;
  end

  // Clear has priority over start/stop except in IDLE, where clear is a no-op.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_ss_edge) w_next = ST_RUN;
      ST_RUN: begin
        if (w_clr_edge)     w_next = ST_IDLE;
        else if (w_ss_edge) w_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_clr_edge)     w_next = ST_IDLE;
        else if (w_ss_edge) w_next = ST_RUN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Only ticks seen while already running, with no button edge, are counted;
  // this drops the tick coinciding with a start or stop press.
  always_comb begin
    w_count    = (r_state == ST_RUN) && w_div_edge && !w_ss_edge && !w_clr_edge;
    w_sec_tick = w_count && (r_presc == LP_PRESC_LAST);

    w_c0   = (r_sec_ones == 4'd9);
    w_c1   = w_c0 && (r_sec_tens == 4'd5);
    w_c2   = w_c1 && (r_min_ones == 4'd9);
    w_wrap = w_sec_tick && w_c2 && (r_min_tens == 4'd5);

    w_sec_ones_n = w_c0 ? 4'd0 : r_sec_ones + 4'd1;
    w_sec_tens_n = r_sec_tens;
    w_min_ones_n = r_min_ones;
    w_min_tens_n = r_min_tens;
    if (w_c0) w_sec_tens_n = (r_sec_tens == 4'd5) ? 4'd0 : r_sec_tens + 4'd1;
    if (w_c1) w_min_ones_n = (r_min_ones == 4'd9) ? 4'd0 : r_min_ones + 4'd1;
    if (w_c2) w_min_tens_n = (r_min_tens == 4'd5) ? 4'd0 : r_min_tens + 4'd1;
  end

  always_ff @(posedge iClk_in) begin
    if (iRst) begin
      r_state    <= ST_IDLE;
      // Loading 1 hides an input that is already high when reset releases.
      r_div_prev <= 1'b1;
      r_ss_prev  <= 1'b1;
      r_clr_prev <= 1'b1;
      r_presc    <= 8'd0;
      r_sec_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_min_tens <= 4'd0;
      r_run      <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_div_prev <= bus.iDivClk;
      r_ss_prev  <= bus.iStartStop;
      r_clr_prev <= bus.iClear;
      r_run      <= (w_next == ST_RUN);
      r_wrap     <= w_wrap;
      if (w_next == ST_IDLE) begin
        r_presc    <= 8'd0;
        r_sec_ones <= 4'd0;
        r_sec_tens <= 4'd0;
        r_min_ones <= 4'd0;
        r_min_tens <= 4'd0;
      end else if (w_count) begin
        if (w_sec_tick) begin
          r_presc    <= 8'd0;
          r_sec_ones <= w_sec_ones_n;
          r_sec_tens <= w_sec_tens_n;
          r_min_ones <= w_min_ones_n;
          r_min_tens <= w_min_tens_n;
        end else begin
          r_presc <= r_presc + 8'd1;
        end
      end
    end
  end

  assign bus.oSec_ones = r_sec_ones;
  assign bus.oSec_tens = r_sec_tens;
  assign bus.oMin_ones = r_min_ones;
  assign bus.oMin_tens = r_min_tens;
  assign bus.oRun      = r_run;
  assign bus.oWrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - self-checking bench for stopwatch_bcd
module tb_stopwatch_bcd;
  localparam int TPS  = 2;
  localparam int FULL = TPS * 3600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stopwatch_bcd_if u_if ();
  stopwatch_bcd #(.TICKS_PER_SEC(TPS)) dut (.iClk_in(clk), .iRst(rst), .bus(u_if));

  int checks = 0;
  int failures = 0;

  // Reference: mode (0 idle, 1 run, 2 pause) and counted divclk ticks since clear.
  int   m_state;
  int   m_ticks;
  logic m_wrap;
  logic p_div, p_ss, p_clr;
  logic d_div, d_ss, d_clr, d_rst;

  function automatic logic [15:0] m_time();
    int s;
    s = m_ticks / TPS;
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dut_time();
    return {u_if.oMin_tens, u_if.oMin_ones, u_if.oSec_tens, u_if.oSec_ones};
  endfunction

  task automatic model_step();
    logic de, se, ce;
    de = d_div & ~p_div;
    se = d_ss & ~p_ss;
    ce = d_clr & ~p_clr;
    m_wrap = 1'b0;
    if (d_rst) begin
      m_state = 0;
      m_ticks = 0;
      p_div = 1'b1; p_ss = 1'b1; p_clr = 1'b1;
    end else begin
      case (m_state)
        0: if (se) m_state = 1;
        1: begin
          if (ce) begin m_state = 0; m_ticks = 0; end
          else if (se) m_state = 2;
          else if (de) begin
            m_ticks++;
            if (m_ticks == FULL) begin m_ticks = 0; m_wrap = 1'b1; end
          end
        end
        2: begin
          if (ce) begin m_state = 0; m_ticks = 0; end
          else if (se) m_state = 1;
        end
        default: m_state = 0;
      endcase
      p_div = d_div; p_ss = d_ss; p_clr = d_clr;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    rst = d_rst;
    u_if.iDivClk = d_div;
    u_if.iStartStop = d_ss;
    u_if.iClear = d_clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic div_edges(input int n, input int half);
    repeat (n) begin
      d_div = 1'b1;
      repeat (half) cyc();
      d_div = 1'b0;
      repeat (half) cyc();
    end
  endtask

  task automatic press_ss();
    d_ss = 1'b1; cyc();
    d_ss = 1'b0; cyc();
  endtask

  task automatic press_clr();
    d_clr = 1'b1; cyc();
    d_clr = 1'b0; cyc();
  endtask

  task automatic test_reset();
    d_rst = 1'b1; d_ss = 1'b1;
    cyc(); cyc();
    d_rst = 1'b0;
    cyc(); cyc();
    checks++; if (dut_time() !== 16'h0000) begin failures++; $display("FAIL reset_time got=%h exp=0000", dut_time()); end
    checks++; if (u_if.oRun !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", u_if.oRun); end
    checks++; if (u_if.oWrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", u_if.oWrap); end
    d_ss = 1'b0;
    cyc();
    div_edges(2, 3);
    checks++; if (u_if.oRun !== 1'b0) begin failures++; $display("FAIL held_ss_no_start got=%b exp=0", u_if.oRun); end
    checks++; if (dut_time() !== 16'h0000) begin failures++; $display("FAIL idle_no_count got=%h exp=0000", dut_time()); end
  endtask

  task automatic test_count();
    press_ss();
    checks++; if (u_if.oRun !== 1'b1) begin failures++; $display("FAIL start_run got=%b exp=1", u_if.oRun); end
    div_edges(1, 3);
    checks++; if (dut_time() !== 16'h0000) begin failures++; $display("FAIL count_edge1 got=%h exp=0000", dut_time()); end
    div_edges(1, 3);
    checks++; if (dut_time() !== 16'h0001) begin failures++; $display("FAIL count_edge2 got=%h exp=0001", dut_time()); end
    div_edges(18, 3);
    checks++; if (dut_time() !== 16'h0010) begin failures++; $display("FAIL count_edge20 got=%h exp=0010", dut_time()); end
    checks++; if (dut_time() !== m_time()) begin failures++; $display("FAIL count_model got=%h exp=%h", dut_time(), m_time()); end
  endtask

  task automatic test_pause();
    press_clr();
    checks++; if (dut_time() !== 16'h0000 || u_if.oRun !== 1'b0) begin failures++; $display("FAIL clear_run got=%h/%b exp=0000/0", dut_time(), u_if.oRun); end
    press_ss();
    div_edges(3, 3);
    checks++; if (dut_time() !== 16'h0001) begin failures++; $display("FAIL pause_pre got=%h exp=0001", dut_time()); end
    press_ss();
    checks++; if (u_if.oRun !== 1'b0) begin failures++; $display("FAIL pause_run got=%b exp=0", u_if.oRun); end
    div_edges(10, 3);
    checks++; if (dut_time() !== 16'h0001) begin failures++; $display("FAIL pause_hold got=%h exp=0001", dut_time()); end
    press_ss();
    checks++; if (u_if.oRun !== 1'b1) begin failures++; $display("FAIL resume_run got=%b exp=1", u_if.oRun); end
    div_edges(1, 3);
    checks++; if (dut_time() !== 16'h0002) begin failures++; $display("FAIL resume_partial got=%h exp=0002", dut_time()); end
  endtask

  task automatic test_suppress();
    press_clr();
    d_ss = 1'b1; d_div = 1'b1; cyc();
    d_ss = 1'b0; d_div = 1'b0; cyc();
    div_edges(1, 3);
    checks++; if (dut_time() !== 16'h0000) begin failures++; $display("FAIL start_edge_counted got=%h exp=0000", dut_time()); end
    div_edges(1, 3);
    checks++; if (dut_time() !== 16'h0001) begin failures++; $display("FAIL after_start got=%h exp=0001", dut_time()); end
    div_edges(1, 3);
    d_ss = 1'b1; d_div = 1'b1; cyc();
    d_ss = 1'b0; d_div = 1'b0; cyc();
    checks++; if (dut_time() !== 16'h0001 || u_if.oRun !== 1'b0) begin failures++; $display("FAIL stop_edge_counted got=%h/%b exp=0001/0", dut_time(), u_if.oRun); end
  endtask

  task automatic test_wrap();
    int nw;
    nw = 0;
    press_clr();
    press_ss();
    div_edges(3598 * TPS, 1);
    checks++; if (dut_time() !== 16'h5958) begin failures++; $display("FAIL preload got=%h exp=5958", dut_time()); end
    div_edges(2, 3);
    checks++; if (dut_time() !== 16'h5959) begin failures++; $display("FAIL pre_wrap got=%h exp=5959", dut_time()); end
    repeat (2) begin
      for (int ph = 0; ph < 2; ph++) begin
        d_div = (ph == 0);
        repeat (3) begin
          cyc();
          if (u_if.oWrap === 1'b1) nw++;
          checks++; if (u_if.oWrap !== m_wrap) begin failures++; $display("FAIL wrap_pulse got=%b exp=%b", u_if.oWrap, m_wrap); end
        end
      end
    end
    checks++; if (nw != 1) begin failures++; $display("FAIL wrap_count got=%0d exp=1", nw); end
    checks++; if (dut_time() !== 16'h0000) begin failures++; $display("FAIL wrap_time got=%h exp=0000", dut_time()); end
    checks++; if (u_if.oRun !== 1'b1) begin failures++; $display("FAIL wrap_run got=%b exp=1", u_if.oRun); end
  endtask

  task automatic test_clear_and_ss();
    press_clr();
    press_ss();
    div_edges(10, 3);
    checks++; if (dut_time() !== 16'h0005) begin failures++; $display("FAIL pre_clear got=%h exp=0005", dut_time()); end
    d_clr = 1'b1; d_ss = 1'b1; cyc();
    checks++; if (dut_time() !== 16'h0000 || u_if.oRun !== 1'b0) begin failures++; $display("FAIL clear_wins got=%h/%b exp=0000/0", dut_time(), u_if.oRun); end
    d_clr = 1'b0; d_ss = 1'b0; cyc();
  endtask

  task automatic test_reset_mid();
    press_ss();
    div_edges(754 * TPS, 1);
    checks++; if (dut_time() !== 16'h1234) begin failures++; $display("FAIL pre_reset got=%h exp=1234", dut_time()); end
    d_rst = 1'b1; cyc();
    d_rst = 1'b0;
    checks++; if (dut_time() !== 16'h0000 || u_if.oRun !== 1'b0 || u_if.oWrap !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%h/%b/%b exp=0000/0/0", dut_time(), u_if.oRun, u_if.oWrap);
    end
    div_edges(2, 3);
    checks++; if (dut_time() !== 16'h0000) begin failures++; $display("FAIL post_reset_count got=%h exp=0000", dut_time()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) d_div = ~d_div;
      d_ss  = ($urandom_range(0, 5) == 0);
      d_clr = ($urandom_range(0, 15) == 0);
      d_rst = ($urandom_range(0, 99) == 0);
      cyc();
      checks++; if (dut_time() !== m_time()) begin failures++; $display("FAIL rand_time cyc=%0d got=%h exp=%h", i, dut_time(), m_time()); end
      checks++; if (u_if.oRun !== (m_state == 1)) begin failures++; $display("FAIL rand_run cyc=%0d got=%b exp=%b", i, u_if.oRun, (m_state == 1)); end
      checks++; if (u_if.oWrap !== m_wrap) begin failures++; $display("FAIL rand_wrap cyc=%0d got=%b exp=%b", i, u_if.oWrap, m_wrap); end
    end
    d_rst = 1'b0; d_ss = 1'b0; d_clr = 1'b0; d_div = 1'b0;
    cyc();
  endtask

  initial begin
    rst = 1'b1;
    u_if.iDivClk = 1'b0;
    u_if.iStartStop = 1'b0;
    u_if.iClear = 1'b0;
    d_div = 1'b0; d_ss = 1'b0; d_clr = 1'b0; d_rst = 1'b1;
    m_state = 0; m_ticks = 0; m_wrap = 1'b0;
    p_div = 1'b1; p_ss = 1'b1; p_clr = 1'b1;
    test_reset();
    test_count();
    test_pause();
    test_suppress();
    test_wrap();
    test_clear_and_ss();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
